// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V uop sequencer: element-offset type, default
// vector-length width and the sequencer FSM state encoding.
package rv32v_types_pkg;

    localparam int VL_WIDTH = 7;

    typedef logic [VL_WIDTH-1:0] offset_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/rv32v_uop_sequencer.sv
// Splits one decoded vector instruction into two-element uops (lane 0/1),
// issuing one uop per cycle with stall hold, flush abort and back-to-back reload.
module rv32v_uop_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int VL_WIDTH = rv32v_types_pkg::VL_WIDTH
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [VL_WIDTH:0]        vl,
    input  logic [VL_WIDTH:0]        vstart,
    input  logic                     vm,
    input  logic [2**VL_WIDTH-1:0]   vmask,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output offset_t                  woffset0,
    output offset_t                  woffset1,
    output logic                     wen0,
    output logic                     wen1,
    output logic                     mask0,
    output logic                     mask1,
    output logic                     last_uop
);

    seq_state_e               state_q, state_d;
    logic [VL_WIDTH:0]        cnt_q, cnt_d;
    logic [VL_WIDTH:0]        vl_q, vl_d;
    logic                     vm_q, vm_d;
    logic [2**VL_WIDTH-1:0]   vmask_q, vmask_d;

    // One extra bit on the +1/+2 sums so the length compares never wrap.
    logic [VL_WIDTH+1:0]      cnt_p1, cnt_p2, vl_ext;
    logic                     run, accept;

    assign run    = (state_q == RUN);
    assign cnt_p1 = {1'b0, cnt_q} + (VL_WIDTH+2)'(1);
    assign cnt_p2 = {1'b0, cnt_q} + (VL_WIDTH+2)'(2);
    assign vl_ext = {1'b0, vl_q};

    // Uop outputs come only from registered state.
    assign out_valid = run;
    assign woffset0  = cnt_q[VL_WIDTH-1:0];
    assign woffset1  = cnt_p1[VL_WIDTH-1:0];
    assign wen0      = (cnt_q < vl_q);
    assign wen1      = (cnt_p1 < vl_ext);
    assign mask0     = vm_q | vmask_q[woffset0];
    assign mask1     = vm_q | vmask_q[woffset1];
    assign last_uop  = run && (cnt_p2 >= vl_ext);

    assign in_ready  = !run || (last_uop && !stall && !flush);
    assign accept    = in_valid && in_ready && !flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vl_q    <= '0;
            vm_q    <= 1'b1;
            vmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vl_q    <= vl_d;
            vm_q    <= vm_d;
            vmask_q <= vmask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vl_d    = vl_q;
        vm_d    = vm_q;
        vmask_d = vmask_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            // Covers both the idle accept and the no-bubble reload on the last uop.
            state_d = RUN;
            cnt_d   = vstart;
            vl_d    = vl;
            vm_d    = vm;
            vmask_d = vmask;
        end else if (run && !stall) begin
            if (last_uop) state_d = IDLE;
            else          cnt_d   = cnt_p2[VL_WIDTH:0];
        end
    end

endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Randomized and directed bench for rv32v_uop_sequencer against an
// element-list reference model of the uop stream.
module tb_rv32v_uop_sequencer;

    localparam int VLW = 7;
    localparam int NEL = 2**VLW;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [VLW:0]     vl = '0;
    logic [VLW:0]     vstart = '0;
    logic             vm = 1'b1;
    logic [NEL-1:0]   vmask = '0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic [VLW-1:0]   woffset0, woffset1;
    logic             wen0, wen1, mask0, mask1, last_uop;

    always #5 CLK = ~CLK;

    rv32v_uop_sequencer dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .vl(vl), .vstart(vstart), .vm(vm), .vmask(vmask),
        .stall(stall), .flush(flush), .out_valid(out_valid),
        .woffset0(woffset0), .woffset1(woffset1), .wen0(wen0), .wen1(wen1),
        .mask0(mask0), .mask1(mask1), .last_uop(last_uop)
    );

    typedef struct packed {
        logic           v;
        logic [VLW-1:0] o0;
        logic [VLW-1:0] o1;
        logic           w0, w1, m0, m1, l;
    } uop_t;

    uop_t obs;
    assign obs = {out_valid, woffset0, woffset1, wen0, wen1, mask0, mask1, last_uop};

    int errors = 0;
    int checks = 0;

    function automatic int n_uops(int l, int s);
        if (s >= l) return 1;
        return (l - s + 1) / 2;
    endfunction

    // Expected k-th uop: elements vstart+2k and vstart+2k+1.
    function automatic uop_t model(int l, int s, logic m, logic [NEL-1:0] mk, int k);
        uop_t u;
        int   e;
        e    = s + 2*k;
        u.v  = 1'b1;
        u.o0 = VLW'(e % NEL);
        u.o1 = VLW'((e + 1) % NEL);
        u.w0 = (e < l);
        u.w1 = (e + 1 < l);
        u.m0 = m | mk[(e) % NEL];
        u.m1 = m | mk[(e + 1) % NEL];
        u.l  = (k == n_uops(l, s) - 1);
        return u;
    endfunction

    function automatic uop_t reset_uop();
        uop_t u;
        u = '0;
        u.o1 = VLW'(1);
        u.m0 = 1'b1;
        u.m1 = 1'b1;
        return u;
    endfunction

    // Presents one instruction for a single cycle; called just after a rising edge.
    task automatic issue(input int l, input int s, input logic m, input logic [NEL-1:0] mk);
        in_valid = 1'b1;
        vl       = (VLW+1)'(l);
        vstart   = (VLW+1)'(s);
        vm       = m;
        vmask    = mk;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [NEL-1:0] rand_mask();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (obs !== reset_uop() || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got %h rdy=%b want %h rdy=1", obs, in_ready, reset_uop());
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (obs !== reset_uop() || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got %h rdy=%b want %h", obs, in_ready, reset_uop());
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_directed();
        int tl[6] = '{5, 4, 2, 128, 1, 0};
        int ts[6] = '{0, 1, 2, 0,   0, 0};
        uop_t exp;
        for (int t = 0; t < 6; t++) begin
            issue(tl[t], ts[t], 1'b1, '0);
            for (int k = 0; k < n_uops(tl[t], ts[t]); k++) begin
                exp = model(tl[t], ts[t], 1'b1, '0, k);
                @(negedge CLK);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL directed vl=%0d vs=%0d uop%0d: got %h want %h", tl[t], ts[t], k, obs, exp);
                end
                @(posedge CLK); #1;
            end
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_idle vl=%0d: valid=%b rdy=%b want 0/1", tl[t], out_valid, in_ready);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_mask_stall();
        logic [NEL-1:0] mk;
        uop_t exp;
        mk = '0;
        mk[3:0] = 4'b1010;
        issue(4, 0, 1'b0, mk);
        stall = 1'b1;
        exp = model(4, 0, 1'b0, mk, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (obs !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: got %h rdy=%b want %h rdy=0", c, obs, in_ready, exp);
            end
            @(posedge CLK); #1;
        end
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp = model(4, 0, 1'b0, mk, k);
            @(negedge CLK);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mask uop%0d: got %h want %h", k, obs, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_random();
        int l, s, k, guard;
        logic m;
        logic [NEL-1:0] mk;
        uop_t exp;
        for (int t = 0; t < 12; t++) begin
            l  = $urandom_range(NEL);
            s  = $urandom_range(l + 2 > NEL ? NEL : l + 2);
            m  = 1'($urandom_range(1));
            mk = rand_mask();
            issue(l, s, m, mk);
            k = 0;
            guard = 0;
            while (k < n_uops(l, s) && guard < 400) begin
                stall = ($urandom_range(3) == 0);
                exp = model(l, s, m, mk, k);
                @(negedge CLK);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random vl=%0d vs=%0d uop%0d: got %h want %h", l, s, k, obs, exp);
                end
                @(posedge CLK); #1;
                if (!stall) k++;
                guard++;
            end
            stall = 1'b0;
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0 || guard >= 400) begin
                errors++;
                $display("FAIL random_end vl=%0d vs=%0d: valid=%b guard=%0d want 0", l, s, out_valid, guard);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [NEL-1:0] mk;
        uop_t exp;
        mk = rand_mask();
        issue(3, 0, 1'b1, '0);
        @(negedge CLK);
        checks++;
        if (obs !== model(3, 0, 1'b1, '0, 0) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %h rdy=%b want %h rdy=0", obs, in_ready, model(3, 0, 1'b1, '0, 0));
        end
        @(posedge CLK); #1;
        in_valid = 1'b1;
        vl = 8'd6; vstart = 8'd1; vm = 1'b0; vmask = mk;
        @(negedge CLK);
        checks++;
        if (obs !== model(3, 0, 1'b1, '0, 1) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last: got %h rdy=%b want %h rdy=1", obs, in_ready, model(3, 0, 1'b1, '0, 1));
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        for (int k = 0; k < n_uops(6, 1); k++) begin
            exp = model(6, 1, 1'b0, mk, k);
            @(negedge CLK);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b_second uop%0d: got %h want %h", k, obs, exp);
            end
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: valid=%b want 0", out_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_flush();
        issue(8, 0, 1'b1, '0);
        @(negedge CLK);
        checks++;
        if (obs !== model(8, 0, 1'b1, '0, 0)) begin
            errors++;
            $display("FAIL flush_uop0: got %h want %h", obs, model(8, 0, 1'b1, '0, 0));
        end
        @(posedge CLK); #1;
        // New instruction and stall both present with flush: flush wins.
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1;
        vl = 8'd4; vstart = 8'd0;
        @(negedge CLK);
        checks++;
        if (obs !== model(8, 0, 1'b1, '0, 1)) begin
            errors++;
            $display("FAIL flush_uop1: got %h want %h", obs, model(8, 0, 1'b1, '0, 1));
        end
        @(posedge CLK); #1;
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: valid=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        issue(20, 0, 1'b0, rand_mask());
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (obs !== reset_uop() || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got %h rdy=%b want %h rdy=1", obs, in_ready, reset_uop());
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_after cyc%0d: valid=%b want 0", c, out_valid);
            end
            @(posedge CLK); #1;
        end
        issue(2, 0, 1'b1, '0);
        @(negedge CLK);
        checks++;
        if (obs !== model(2, 0, 1'b1, '0, 0)) begin
            errors++;
            $display("FAIL reset_new: got %h want %h", obs, model(2, 0, 1'b1, '0, 0));
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        nRST = 1'b1;
        #2 nRST = 1'b0;
        test_reset();
        test_directed();
        test_mask_stall();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
